// File: rtl/dmac_ctrl_mux.sv
// Control-port front-end for the cluster DMA.
// Merges several control ports onto one command port using round-robin
// arbitration. A small FIFO records the source port and requester id of each
// accepted command, so the in-order downstream responses can be routed back
// to the port that issued them.
module dmac_ctrl_mux #(
    parameter int NB_CTRLS    = 10,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int PE_ID_WIDTH = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NB_CTRLS-1:0]                 ctrl_req_i,
    input  logic [NB_CTRLS*ADDR_WIDTH-1:0]      ctrl_add_i,
    input  logic [NB_CTRLS-1:0]                 ctrl_wen_i,
    input  logic [NB_CTRLS*(DATA_WIDTH/8)-1:0]  ctrl_be_i,
    input  logic [NB_CTRLS*DATA_WIDTH-1:0]      ctrl_wdata_i,
    input  logic [NB_CTRLS*PE_ID_WIDTH-1:0]     ctrl_id_i,
    output logic [NB_CTRLS-1:0]                 ctrl_gnt_o,
    output logic [NB_CTRLS-1:0]                 ctrl_r_valid_o,
    output logic [DATA_WIDTH-1:0]               ctrl_r_rdata_o,
    output logic                                ctrl_r_opc_o,
    output logic [PE_ID_WIDTH-1:0]              ctrl_r_id_o,
    output logic                                cmd_valid_o,
    input  logic                                cmd_ready_i,
    output logic [ADDR_WIDTH-1:0]               cmd_add_o,
    output logic                                cmd_wen_o,
    output logic [DATA_WIDTH/8-1:0]             cmd_be_o,
    output logic [DATA_WIDTH-1:0]               cmd_wdata_o,
    output logic [$clog2(NB_CTRLS)-1:0]         cmd_src_o,
    input  logic                                rsp_valid_i,
    input  logic [DATA_WIDTH-1:0]               rsp_rdata_i,
    input  logic                                rsp_opc_i,
    output logic                                busy_o,
    output logic                                err_o
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int SRC_WIDTH = $clog2(NB_CTRLS);
    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);

    // Per-port fields unpacked from the flat input buses
    logic [ADDR_WIDTH-1:0]  add_arr   [NB_CTRLS];
    logic [BE_WIDTH-1:0]    be_arr    [NB_CTRLS];
    logic [DATA_WIDTH-1:0]  wdata_arr [NB_CTRLS];
    logic [PE_ID_WIDTH-1:0] id_arr    [NB_CTRLS];

    // Arbitration state
    logic [SRC_WIDTH-1:0]   rr_ptr_reg;
    logic [SRC_WIDTH-1:0]   rr_ptr_next;
    logic [SRC_WIDTH-1:0]   winner;
    logic                   any_req;
    logic                   accept;

    // Source-tracking FIFO; the extra pointer MSB separates full from empty
    logic [SRC_WIDTH-1:0]   src_mem [FIFO_DEPTH];
    logic [PE_ID_WIDTH-1:0] id_mem  [FIFO_DEPTH];
    logic [PTR_WIDTH:0]     wr_ptr_reg;
    logic [PTR_WIDTH:0]     rd_ptr_reg;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   push;
    logic                   pop;

    // Registered response side
    logic [NB_CTRLS-1:0]    r_valid_reg;
    logic [NB_CTRLS-1:0]    r_valid_next;
    logic [DATA_WIDTH-1:0]  r_rdata_reg;
    logic                   r_opc_reg;
    logic [PE_ID_WIDTH-1:0] r_id_reg;
    logic                   err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NB_CTRLS; gi++) begin : g_port
            assign add_arr[gi]    = ctrl_add_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign be_arr[gi]     = ctrl_be_i[gi*BE_WIDTH +: BE_WIDTH];
            assign wdata_arr[gi]  = ctrl_wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
            assign id_arr[gi]     = ctrl_id_i[gi*PE_ID_WIDTH +: PE_ID_WIDTH];
            assign ctrl_gnt_o[gi] = accept && (winner == SRC_WIDTH'(gi));
        end
    endgenerate

    // Round-robin scan: the first requester at or after the pointer wins.
    // Scanning from the farthest offset down lets the nearest one overwrite.
    always_comb begin : winner_scan
        int scan_idx;
        scan_idx = 0;
        winner   = rr_ptr_reg;
        for (int k = NB_CTRLS - 1; k >= 0; k--) begin
            scan_idx = int'(rr_ptr_reg) + k;
            if (scan_idx >= NB_CTRLS) begin
                scan_idx = scan_idx - NB_CTRLS;
            end
            if (ctrl_req_i[scan_idx]) begin
                winner = SRC_WIDTH'(scan_idx);
            end
        end
    end

    assign any_req     = |ctrl_req_i;
    assign fifo_empty  = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full   = (wr_ptr_reg[PTR_WIDTH] != rd_ptr_reg[PTR_WIDTH]) &&
                         (wr_ptr_reg[PTR_WIDTH-1:0] == rd_ptr_reg[PTR_WIDTH-1:0]);
    // Full blocks acceptance even if a pop happens this cycle (no bypass)
    assign cmd_valid_o = any_req && !fifo_full;
    assign accept      = cmd_valid_o && cmd_ready_i;
    assign push        = accept;
    assign pop         = rsp_valid_i && !fifo_empty;
    assign rr_ptr_next = (winner == SRC_WIDTH'(NB_CTRLS - 1)) ? '0
                                                               : winner + SRC_WIDTH'(1);

    assign cmd_add_o   = add_arr[winner];
    assign cmd_wen_o   = ctrl_wen_i[winner];
    assign cmd_be_o    = be_arr[winner];
    assign cmd_wdata_o = wdata_arr[winner];
    assign cmd_src_o   = winner;

    // One-hot response pulse towards the port at the FIFO head
    always_comb begin
        r_valid_next = '0;
        if (pop) begin
            r_valid_next[src_mem[rd_ptr_reg[PTR_WIDTH-1:0]]] = 1'b1;
        end
    end

    // Round-robin pointer advances only past an accepted winner
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_reg <= '0;
        end else if (accept) begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    // FIFO storage: no reset needed, occupancy is tracked by the pointers
    always_ff @(posedge clk_i) begin
        if (push) begin
            src_mem[wr_ptr_reg[PTR_WIDTH-1:0]] <= winner;
            id_mem[wr_ptr_reg[PTR_WIDTH-1:0]]  <= id_arr[winner];
        end
    end

    // FIFO pointers; a simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + (PTR_WIDTH+1)'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + (PTR_WIDTH+1)'(1);
            end
        end
    end

    // Response registers: data/opc/id hold their value between pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid_reg <= '0;
            r_rdata_reg <= '0;
            r_opc_reg   <= 1'b0;
            r_id_reg    <= '0;
        end else begin
            r_valid_reg <= r_valid_next;
            if (pop) begin
                r_rdata_reg <= rsp_rdata_i;
                r_opc_reg   <= rsp_opc_i;
                r_id_reg    <= id_mem[rd_ptr_reg[PTR_WIDTH-1:0]];
            end
        end
    end

    // Sticky error: a response arrived with nothing outstanding
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_reg <= 1'b0;
        end else if (rsp_valid_i && fifo_empty) begin
            err_reg <= 1'b1;
        end
    end

    assign ctrl_r_valid_o = r_valid_reg;
    assign ctrl_r_rdata_o = r_rdata_reg;
    assign ctrl_r_opc_o   = r_opc_reg;
    assign ctrl_r_id_o    = r_id_reg;
    assign err_o          = err_reg;
    assign busy_o         = !fifo_empty || (|r_valid_reg);

endmodule

// File: tb/tb_dmac_ctrl_mux.sv
// Randomized bench for dmac_ctrl_mux against a queue-based reference model.
module tb_dmac_ctrl_mux;

    localparam int NB = 10;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int IW = 4;
    localparam int FD = 4;
    localparam int SW = $clog2(NB);

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [NB-1:0]     ctrl_req_i;
    logic [NB*AW-1:0]  ctrl_add_i;
    logic [NB-1:0]     ctrl_wen_i;
    logic [NB*BW-1:0]  ctrl_be_i;
    logic [NB*DW-1:0]  ctrl_wdata_i;
    logic [NB*IW-1:0]  ctrl_id_i;
    logic [NB-1:0]     ctrl_gnt_o;
    logic [NB-1:0]     ctrl_r_valid_o;
    logic [DW-1:0]     ctrl_r_rdata_o;
    logic              ctrl_r_opc_o;
    logic [IW-1:0]     ctrl_r_id_o;
    logic              cmd_valid_o;
    logic              cmd_ready_i;
    logic [AW-1:0]     cmd_add_o;
    logic              cmd_wen_o;
    logic [BW-1:0]     cmd_be_o;
    logic [DW-1:0]     cmd_wdata_o;
    logic [SW-1:0]     cmd_src_o;
    logic              rsp_valid_i;
    logic [DW-1:0]     rsp_rdata_i;
    logic              rsp_opc_i;
    logic              busy_o;
    logic              err_o;

    dmac_ctrl_mux #(
        .NB_CTRLS   (NB),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .PE_ID_WIDTH(IW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .ctrl_req_i    (ctrl_req_i),
        .ctrl_add_i    (ctrl_add_i),
        .ctrl_wen_i    (ctrl_wen_i),
        .ctrl_be_i     (ctrl_be_i),
        .ctrl_wdata_i  (ctrl_wdata_i),
        .ctrl_id_i     (ctrl_id_i),
        .ctrl_gnt_o    (ctrl_gnt_o),
        .ctrl_r_valid_o(ctrl_r_valid_o),
        .ctrl_r_rdata_o(ctrl_r_rdata_o),
        .ctrl_r_opc_o  (ctrl_r_opc_o),
        .ctrl_r_id_o   (ctrl_r_id_o),
        .cmd_valid_o   (cmd_valid_o),
        .cmd_ready_i   (cmd_ready_i),
        .cmd_add_o     (cmd_add_o),
        .cmd_wen_o     (cmd_wen_o),
        .cmd_be_o      (cmd_be_o),
        .cmd_wdata_o   (cmd_wdata_o),
        .cmd_src_o     (cmd_src_o),
        .rsp_valid_i   (rsp_valid_i),
        .rsp_rdata_i   (rsp_rdata_i),
        .rsp_opc_i     (rsp_opc_i),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: outstanding commands as a queue of {port, id}
    typedef struct {
        int          src;
        logic [IW-1:0] id;
    } ent_t;

    ent_t          mdl_q[$];
    int            mdl_ptr;
    bit            mdl_err;
    logic [NB-1:0] mdl_rvalid;
    logic [DW-1:0] mdl_rdata;
    logic          mdl_opc;
    logic [IW-1:0] mdl_rid;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s cyc=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        mdl_q.delete();
        mdl_ptr    = 0;
        mdl_err    = 1'b0;
        mdl_rvalid = '0;
        mdl_rdata  = '0;
        mdl_opc    = 1'b0;
        mdl_rid    = '0;
    endtask

    // Inputs are already driven (at the falling edge); check, then advance one clock
    task automatic run_cycle();
        int            w;
        bit            exp_valid;
        bit            exp_acc;
        logic [NB-1:0] exp_gnt;
        logic [NB-1:0] new_rvalid;
        ent_t          e;
        #1;
        w = -1;
        for (int k = 0; k < NB; k++) begin
            int idx;
            idx = (mdl_ptr + k) % NB;
            if (w < 0 && ctrl_req_i[idx]) w = idx;
        end
        exp_valid = (w >= 0) && (mdl_q.size() < FD);
        exp_acc   = exp_valid && cmd_ready_i;
        exp_gnt   = '0;
        if (exp_acc) exp_gnt[w] = 1'b1;

        check_val("cmd_valid", 64'(cmd_valid_o), 64'(exp_valid));
        check_val("gnt", 64'(ctrl_gnt_o), 64'(exp_gnt));
        if (exp_valid) begin
            check_val("cmd_src", 64'(cmd_src_o), 64'(w));
            check_val("cmd_add", 64'(cmd_add_o), 64'(ctrl_add_i[w*AW +: AW]));
            check_val("cmd_wen", 64'(cmd_wen_o), 64'(ctrl_wen_i[w]));
            check_val("cmd_be", 64'(cmd_be_o), 64'(ctrl_be_i[w*BW +: BW]));
            check_val("cmd_wdata", 64'(cmd_wdata_o), 64'(ctrl_wdata_i[w*DW +: DW]));
        end
        check_val("r_valid", 64'(ctrl_r_valid_o), 64'(mdl_rvalid));
        check_val("r_rdata", 64'(ctrl_r_rdata_o), 64'(mdl_rdata));
        check_val("r_opc", 64'(ctrl_r_opc_o), 64'(mdl_opc));
        check_val("r_id", 64'(ctrl_r_id_o), 64'(mdl_rid));
        check_val("busy", 64'(busy_o), 64'((mdl_q.size() != 0) || (mdl_rvalid != 0)));
        check_val("err", 64'(err_o), 64'(mdl_err));

        if (exp_acc && !rst_i)
            $display("[TB] cyc=%0d accept port=%0d id=%0d wen=%0d", cyc, w,
                     ctrl_id_i[w*IW +: IW], ctrl_wen_i[w]);
        if (mdl_rvalid != 0)
            $display("[TB] cyc=%0d response r_valid=0x%0h rdata=0x%0h id=%0d", cyc,
                     mdl_rvalid, mdl_rdata, mdl_rid);

        @(posedge clk_i);
        if (rst_i) begin
            model_reset();
        end else begin
            new_rvalid = '0;
            if (rsp_valid_i && mdl_q.size() > 0) begin
                e = mdl_q.pop_front();
                new_rvalid[e.src] = 1'b1;
                mdl_rdata = rsp_rdata_i;
                mdl_opc   = rsp_opc_i;
                mdl_rid   = e.id;
            end else if (rsp_valid_i) begin
                mdl_err = 1'b1;
            end
            if (exp_acc) begin
                e.src = w;
                e.id  = ctrl_id_i[w*IW +: IW];
                mdl_q.push_back(e);
                mdl_ptr = (w + 1) % NB;
            end
            mdl_rvalid = new_rvalid;
        end
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic randomize_fields();
        for (int p = 0; p < NB; p++) begin
            ctrl_add_i[p*AW +: AW]   = $urandom;
            ctrl_wdata_i[p*DW +: DW] = $urandom;
            ctrl_be_i[p*BW +: BW]    = BW'($urandom);
            ctrl_id_i[p*IW +: IW]    = IW'($urandom);
            ctrl_wen_i[p]            = 1'($urandom);
        end
        rsp_rdata_i = $urandom;
        rsp_opc_i   = 1'($urandom);
    endtask

    task automatic drive_random(input int req_pct, input int rdy_pct, input int rsp_pct);
        randomize_fields();
        for (int p = 0; p < NB; p++) ctrl_req_i[p] = ($urandom_range(99) < req_pct);
        cmd_ready_i = ($urandom_range(99) < rdy_pct);
        rsp_valid_i = ($urandom_range(99) < rsp_pct);
        rst_i       = ($urandom_range(299) == 0);
    endtask

    initial begin
        rst_i        = 1'b1;
        ctrl_req_i   = '0;
        ctrl_add_i   = '0;
        ctrl_wen_i   = '0;
        ctrl_be_i    = '0;
        ctrl_wdata_i = '0;
        ctrl_id_i    = '0;
        cmd_ready_i  = 1'b0;
        rsp_valid_i  = 1'b0;
        rsp_rdata_i  = '0;
        rsp_opc_i    = 1'b0;
        model_reset();
        @(negedge clk_i);
        run_cycle();
        run_cycle();
        rst_i = 1'b0;
        run_cycle();

        // Ports 0, 3, 7 contend with ready high; responses keep the FIFO draining
        for (int i = 0; i < 9; i++) begin
            randomize_fields();
            ctrl_req_i  = '0;
            ctrl_req_i[0] = 1'b1;
            ctrl_req_i[3] = 1'b1;
            ctrl_req_i[7] = 1'b1;
            cmd_ready_i = 1'b1;
            rsp_valid_i = (mdl_q.size() > 0);
            run_cycle();
        end

        // Fill the FIFO with no responses, then release one response
        ctrl_req_i  = '0;
        rsp_valid_i = 1'b0;
        run_cycle();
        while (mdl_q.size() > 0) begin
            rsp_valid_i = 1'b1;
            run_cycle();
        end
        rsp_valid_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            randomize_fields();
            ctrl_req_i  = '1;
            cmd_ready_i = 1'b1;
            rsp_valid_i = (i == 5);
            run_cycle();
        end
        ctrl_req_i  = '0;
        rsp_valid_i = 1'b0;
        run_cycle();

        // Stray response with empty FIFO, then reset with commands outstanding
        while (mdl_q.size() > 0) begin
            rsp_valid_i = 1'b1;
            run_cycle();
        end
        rsp_valid_i = 1'b1;
        run_cycle();
        rsp_valid_i = 1'b0;
        run_cycle();
        ctrl_req_i  = '1;
        cmd_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) run_cycle();
        ctrl_req_i = '0;
        rst_i      = 1'b1;
        run_cycle();
        rst_i = 1'b0;
        run_cycle();
        rsp_valid_i = 1'b1;
        run_cycle();
        rsp_valid_i = 1'b0;
        ctrl_req_i  = '1;
        run_cycle();

        // Randomized phases: response-starved, balanced, response-heavy
        for (int i = 0; i < 800; i++) begin
            drive_random(60, 80, 15);
            run_cycle();
        end
        for (int i = 0; i < 800; i++) begin
            drive_random(40, 70, 50);
            run_cycle();
        end
        for (int i = 0; i < 800; i++) begin
            drive_random(20, 60, 85);
            run_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
